// File: rtl/sf3_spi_flash_responder_pkg.sv
// Shared opcodes, FSM state types and register bit positions for the SF3 SPI flash responder.
package sf3_responder_pkg;

    // N25Q opcode subset used by the PMOD SF3 driver
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_SSE   = 8'h20;
    localparam logic [7:0] OP_RDFSR = 8'h70;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_REG_OUT,
        ST_IGNORE
    } t_resp_state;

    // Action carried out when CSn rises on a byte boundary
    typedef enum logic [2:0] {
        PEND_NONE,
        PEND_WEL_SET,
        PEND_WEL_CLR,
        PEND_ERASE,
        PEND_PROG
    } t_pend_action;

    localparam int STATUS_WIP_BIT = 0;
    localparam int STATUS_WEL_BIT = 1;
    localparam int FLAG_READY_BIT = 7;

    function automatic logic [7:0] f_status_byte(input logic wip, input logic wel);
        logic [7:0] b;
        b = '0;
        b[STATUS_WIP_BIT] = wip;
        b[STATUS_WEL_BIT] = wel;
        return b;
    endfunction

    function automatic logic [7:0] f_flag_byte(input logic wip);
        logic [7:0] b;
        b = '0;
        b[FLAG_READY_BIT] = ~wip;
        return b;
    endfunction

endpackage

// File: rtl/sf3_spi_sync_edge.sv
// Brings SCK, CSn and COPI into the system clock domain and flags SCK edges.
module sf3_spi_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck_i,
    input  logic csn_i,
    input  logic copi_i,
    output logic csn_o,
    output logic copi_o,
    output logic sck_rise_o,
    output logic sck_fall_o
);

    logic sck_m_q, sck_s_q, sck_d_q;
    logic csn_m_q, csn_s_q;
    logic copi_m_q, copi_s_q;

    // Two-flop synchronizers plus a delayed SCK copy for edge detection; CSn idles high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_m_q  <= 1'b0;
            sck_s_q  <= 1'b0;
            sck_d_q  <= 1'b0;
            csn_m_q  <= 1'b1;
            csn_s_q  <= 1'b1;
            copi_m_q <= 1'b0;
            copi_s_q <= 1'b0;
        end else begin
            sck_m_q  <= sck_i;
            sck_s_q  <= sck_m_q;
            sck_d_q  <= sck_s_q;
            csn_m_q  <= csn_i;
            csn_s_q  <= csn_m_q;
            copi_m_q <= copi_i;
            copi_s_q <= copi_m_q;
        end
    end

    assign csn_o      = csn_s_q;
    assign copi_o     = copi_s_q;
    assign sck_rise_o = sck_s_q & ~sck_d_q;
    assign sck_fall_o = ~sck_s_q & sck_d_q;

endmodule

// File: rtl/sf3_spi_flash_responder.sv
// SPI mode-0 responder emulating the N25Q command subset used by the SF3 driver.
// Array storage lives outside; this block issues byte-wide read/write/erase strobes.
module sf3_spi_flash_responder
    import sf3_responder_pkg::*;
#(
    parameter int parm_addr_bytes     = 3,
    parameter int parm_busy_cycles    = 64,
    parameter int parm_subsector_bits = 12
) (
    input  logic                         i_clk_mhz,
    input  logic                         i_rstn_mhz,
    input  logic                         eio_sck_i,
    input  logic                         eio_csn_i,
    input  logic                         eio_copi_dq0_i,
    output logic                         eio_cipo_dq1_o,
    output logic                         eio_cipo_dq1_t,
    output logic [8*parm_addr_bytes-1:0] o_mem_addr,
    output logic                         o_mem_rd_req,
    input  logic [7:0]                   i_mem_rd_data,
    output logic                         o_mem_wr_req,
    output logic [7:0]                   o_mem_wr_data,
    output logic                         o_mem_erase_req,
    output logic [7:0]                   o_reg_status,
    output logic [7:0]                   o_reg_flag
);

    localparam int AW = 8 * parm_addr_bytes;
    localparam int BW = $clog2(parm_busy_cycles + 1);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'((64'd1 << parm_subsector_bits) - 64'd1);

    logic csn_s, copi_s, sck_rise, sck_fall;

    sf3_spi_sync_edge u_sync (
        .clk_i      (i_clk_mhz),
        .rst_ni     (i_rstn_mhz),
        .sck_i      (eio_sck_i),
        .csn_i      (eio_csn_i),
        .copi_i     (eio_copi_dq0_i),
        .csn_o      (csn_s),
        .copi_o     (copi_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall)
    );

    t_resp_state  state_q;
    t_pend_action pend_q;
    logic [2:0]    bit_cnt_q;
    logic [2:0]    addr_cnt_q;
    logic [6:0]    in_sr_q;
    logic [7:0]    out_sr_q;
    logic [7:0]    hold_q;
    logic [7:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wr_data_q;
    logic [BW-1:0] busy_q;
    logic          wip_q, wel_q;
    logic          reg_sel_q;
    logic          rd_first_q, rd_ack_q;
    logic          rd_req_q, wr_req_q, erase_req_q;
    logic          cipo_q, cipo_t_q;
    logic [7:0]    status_q, flag_q;

    logic [7:0] byte_w;
    logic [7:0] reg_byte_w;

    assign byte_w     = {in_sr_q, copi_s};
    assign reg_byte_w = reg_sel_q ? f_flag_byte(wip_q) : f_status_byte(wip_q, wel_q);

    // Protocol FSM, shift registers, busy timer and all registered outputs
    always_ff @(posedge i_clk_mhz or negedge i_rstn_mhz) begin
        if (!i_rstn_mhz) begin
            state_q     <= ST_IDLE;
            pend_q      <= PEND_NONE;
            bit_cnt_q   <= '0;
            addr_cnt_q  <= '0;
            in_sr_q     <= '0;
            out_sr_q    <= '0;
            hold_q      <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            busy_q      <= '0;
            wip_q       <= 1'b0;
            wel_q       <= 1'b0;
            reg_sel_q   <= 1'b0;
            rd_first_q  <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            erase_req_q <= 1'b0;
            cipo_q      <= 1'b0;
            cipo_t_q    <= 1'b1;
            status_q    <= '0;
            flag_q      <= '0;
        end else begin
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            erase_req_q <= 1'b0;
            rd_ack_q    <= rd_req_q;
            status_q    <= f_status_byte(wip_q, wel_q);
            flag_q      <= f_flag_byte(wip_q);
            cipo_t_q    <= csn_s | ~((state_q == ST_REG_OUT) || (state_q == ST_RD_DATA));

            if (busy_q != '0) begin
                busy_q <= busy_q - BW'(1);
                if (busy_q == BW'(1)) wip_q <= 1'b0;
            end

            // Page-wrapping increment lands the cycle after the write strobe was presented
            if (wr_req_q) addr_q[7:0] <= addr_q[7:0] + 8'd1;

            if (sck_fall && !csn_s) begin
                cipo_q   <= out_sr_q[7];
                out_sr_q <= {out_sr_q[6:0], 1'b0};
            end

            // First read byte goes straight to the shifter; later ones are prefetched
            if (rd_ack_q) begin
                if (rd_first_q) begin
                    out_sr_q   <= i_mem_rd_data;
                    rd_first_q <= 1'b0;
                end else begin
                    hold_q <= i_mem_rd_data;
                end
            end

            if (csn_s) begin
                if (state_q != ST_IDLE && bit_cnt_q == 3'd0) begin
                    unique case (pend_q)
                        PEND_WEL_SET: wel_q <= 1'b1;
                        PEND_WEL_CLR: wel_q <= 1'b0;
                        PEND_ERASE: begin
                            erase_req_q <= 1'b1;
                            addr_q      <= addr_q & ALIGN_MASK;
                            wip_q       <= 1'b1;
                            wel_q       <= 1'b0;
                            busy_q      <= BW'(parm_busy_cycles);
                        end
                        PEND_PROG: begin
                            wip_q  <= 1'b1;
                            wel_q  <= 1'b0;
                            busy_q <= BW'(parm_busy_cycles);
                        end
                        default: ;
                    endcase
                end
                state_q    <= ST_IDLE;
                pend_q     <= PEND_NONE;
                bit_cnt_q  <= '0;
                addr_cnt_q <= '0;
                rd_first_q <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                state_q   <= ST_CMD;
                bit_cnt_q <= '0;
            end else if (sck_rise) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                in_sr_q   <= byte_w[6:0];
                unique case (state_q)
                    ST_CMD: begin
                        if (bit_cnt_q == 3'd7) begin
                            op_q <= byte_w;
                            if (byte_w == OP_RDSR || byte_w == OP_RDFSR) begin
                                state_q   <= ST_REG_OUT;
                                reg_sel_q <= (byte_w == OP_RDFSR);
                                out_sr_q  <= (byte_w == OP_RDFSR) ? f_flag_byte(wip_q)
                                                                  : f_status_byte(wip_q, wel_q);
                            end else if (wip_q) begin
                                state_q <= ST_IGNORE;
                            end else begin
                                unique case (byte_w)
                                    OP_WREN: begin
                                        pend_q  <= PEND_WEL_SET;
                                        state_q <= ST_IGNORE;
                                    end
                                    OP_WRDI: begin
                                        pend_q  <= PEND_WEL_CLR;
                                        state_q <= ST_IGNORE;
                                    end
                                    OP_READ, OP_PP, OP_SSE: state_q <= ST_ADDR;
                                    default: state_q <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        addr_q <= {addr_q[AW-2:0], copi_s};
                        if (bit_cnt_q == 3'd7) begin
                            addr_cnt_q <= addr_cnt_q + 3'd1;
                            if (addr_cnt_q == 3'(parm_addr_bytes - 1)) begin
                                if (op_q == OP_READ) begin
                                    rd_req_q   <= 1'b1;
                                    rd_first_q <= 1'b1;
                                    state_q    <= ST_RD_DATA;
                                end else if (op_q == OP_PP) begin
                                    state_q <= wel_q ? ST_WR_DATA : ST_IGNORE;
                                end else begin
                                    if (wel_q) pend_q <= PEND_ERASE;
                                    state_q <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (bit_cnt_q == 3'd0) begin
                            addr_q   <= addr_q + AW'(1);
                            rd_req_q <= 1'b1;
                        end else if (bit_cnt_q == 3'd7) begin
                            out_sr_q <= hold_q;
                        end
                    end
                    ST_WR_DATA: begin
                        if (bit_cnt_q == 3'd7) begin
                            wr_data_q <= byte_w;
                            wr_req_q  <= 1'b1;
                            pend_q    <= PEND_PROG;
                        end
                    end
                    ST_REG_OUT: begin
                        if (bit_cnt_q == 3'd7) out_sr_q <= reg_byte_w;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign eio_cipo_dq1_o  = cipo_q;
    assign eio_cipo_dq1_t  = cipo_t_q;
    assign o_mem_addr      = addr_q;
    assign o_mem_rd_req    = rd_req_q;
    assign o_mem_wr_req    = wr_req_q;
    assign o_mem_wr_data   = wr_data_q;
    assign o_mem_erase_req = erase_req_q;
    assign o_reg_status    = status_q;
    assign o_reg_flag      = flag_q;

endmodule

// File: tb/tb_sf3_spi_flash_responder.sv
// Directed bench for the SF3 SPI flash responder with a byte-addressed memory stub.
module tb_sf3_spi_flash_responder;

    localparam int BUSY = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck, csn, copi;
    logic        cipo, cipo_t;
    logic [23:0] mem_addr;
    logic        rd_req, wr_req, erase_req;
    logic [7:0]  rd_data = 8'h00;
    logic [7:0]  wr_data;
    logic [7:0]  status, flag;

    int tests = 0;
    int fails = 0;

    int          rd_cnt = 0, wr_cnt = 0, er_cnt = 0;
    logic [23:0] rd_addr_log [16];
    logic [23:0] wr_addr_log [16];
    logic [7:0]  wr_data_log [16];
    logic [23:0] er_addr = '0;

    sf3_spi_flash_responder #(
        .parm_addr_bytes     (3),
        .parm_busy_cycles    (BUSY),
        .parm_subsector_bits (12)
    ) dut (
        .i_clk_mhz       (clk),
        .i_rstn_mhz      (rst_n),
        .eio_sck_i       (sck),
        .eio_csn_i       (csn),
        .eio_copi_dq0_i  (copi),
        .eio_cipo_dq1_o  (cipo),
        .eio_cipo_dq1_t  (cipo_t),
        .o_mem_addr      (mem_addr),
        .o_mem_rd_req    (rd_req),
        .i_mem_rd_data   (rd_data),
        .o_mem_wr_req    (wr_req),
        .o_mem_wr_data   (wr_data),
        .o_mem_erase_req (erase_req),
        .o_reg_status    (status),
        .o_reg_flag      (flag)
    );

    always #5 clk = ~clk;

    // Memory stub: read data is the low address byte, one cycle after the strobe
    always @(posedge clk) begin
        if (rd_req) begin
            rd_data <= mem_addr[7:0];
            rd_addr_log[rd_cnt % 16] <= mem_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (wr_req) begin
            wr_addr_log[wr_cnt % 16] <= mem_addr;
            wr_data_log[wr_cnt % 16] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (erase_req) begin
            er_addr <= mem_addr;
            er_cnt  <= er_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_begin();
        tick(1);
        csn = 1'b0;
        tick(8);
    endtask

    task automatic spi_end();
        tick(8);
        csn = 1'b1;
        tick(16);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            copi = tx[7-i];
            tick(8);
            rx[7-i] = cipo;
            sck = 1'b1;
            tick(8);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic spi_cmd(input logic [7:0] op);
        logic [7:0] rx;
        spi_begin();
        spi_byte(op, rx);
        spi_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; csn = 1'b1; sck = 1'b0; copi = 1'b0;
        tick(3);
        tests++;
        if (cipo_t !== 1'b1) begin fails++; $display("FAIL reset_cipo_t: got %b expected 1", cipo_t); end
        tests++;
        if ({status, flag, rd_req, wr_req, erase_req, cipo} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: status=%h flag=%h rd=%b wr=%b er=%b cipo=%b expected all 0",
                     status, flag, rd_req, wr_req, erase_req, cipo);
        end
        tests++;
        if (mem_addr !== 24'h0) begin fails++; $display("FAIL reset_addr: got %h expected 000000", mem_addr); end
        rst_n = 1'b1;
        tick(4);
        tests++;
        if (flag !== 8'h80 || status !== 8'h00) begin
            fails++; $display("FAIL post_reset_regs: status=%h flag=%h expected 00/80", status, flag);
        end
    endtask

    task automatic test_rdsr_wel();
        logic [7:0] b0, b1, rx;
        spi_cmd(8'h06);
        spi_begin();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, b0);
        tests++;
        if (cipo_t !== 1'b0) begin fails++; $display("FAIL rdsr_drive: cipo_t got %b expected 0", cipo_t); end
        spi_byte(8'h00, b1);
        spi_end();
        tests++;
        if (b0 !== 8'h02 || b1 !== 8'h02) begin
            fails++; $display("FAIL rdsr_bytes: got %h %h expected 02 02", b0, b1);
        end
        tests++;
        if (cipo_t !== 1'b1) begin fails++; $display("FAIL rdsr_release: cipo_t got %b expected 1", cipo_t); end
    endtask

    task automatic test_pp_wrap();
        logic [7:0] rx, st, fl;
        int base, wip_cycles;
        logic [23:0] exp_a [3];
        logic [7:0]  exp_d [3];
        exp_a[0] = 24'h0000FE; exp_a[1] = 24'h0000FF; exp_a[2] = 24'h000000;
        exp_d[0] = 8'hA1;      exp_d[1] = 8'hA2;      exp_d[2] = 8'hA3;
        st = '0; fl = '0; wip_cycles = 0;
        base = wr_cnt;
        spi_cmd(8'h06);
        spi_begin();
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'hFE, rx);
        spi_byte(8'hA1, rx); spi_byte(8'hA2, rx); spi_byte(8'hA3, rx);
        tick(8);
        csn = 1'b1;
        for (int i = 0; i < BUSY + 40; i++) begin
            tick(1);
            if (status[0]) wip_cycles++;
            if (i == 20) begin st = status; fl = flag; end
        end
        tests++;
        if (wr_cnt - base !== 3) begin fails++; $display("FAIL pp_wr_count: got %0d expected 3", wr_cnt - base); end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (wr_addr_log[(base+k)%16] !== exp_a[k] || wr_data_log[(base+k)%16] !== exp_d[k]) begin
                fails++;
                $display("FAIL pp_write%0d: got %h=%h expected %h=%h", k,
                         wr_addr_log[(base+k)%16], wr_data_log[(base+k)%16], exp_a[k], exp_d[k]);
            end
        end
        tests++;
        if (st !== 8'h01 || fl !== 8'h00) begin
            fails++; $display("FAIL pp_busy_regs: status=%h flag=%h expected 01/00", st, fl);
        end
        tests++;
        if (wip_cycles !== BUSY) begin fails++; $display("FAIL pp_wip_len: got %0d expected %0d", wip_cycles, BUSY); end
        spi_begin();
        spi_byte(8'h70, rx);
        spi_byte(8'h00, rx);
        spi_end();
        tests++;
        if (rx !== 8'h80) begin fails++; $display("FAIL pp_rdfsr: got %h expected 80", rx); end
    endtask

    task automatic test_read_wrap();
        logic [7:0] rx, d0, d1, d2;
        int base;
        base = rd_cnt;
        spi_begin();
        spi_byte(8'h03, rx); spi_byte(8'hFF, rx); spi_byte(8'hFF, rx); spi_byte(8'hFF, rx);
        spi_byte(8'h00, d0); spi_byte(8'h00, d1); spi_byte(8'h00, d2);
        spi_end();
        tests++;
        if ({d0, d1, d2} !== 24'hFF0001) begin
            fails++; $display("FAIL read_bytes: got %h %h %h expected FF 00 01", d0, d1, d2);
        end
        tests++;
        if (rd_cnt - base !== 4) begin fails++; $display("FAIL read_req_count: got %0d expected 4", rd_cnt - base); end
        tests++;
        if (rd_addr_log[base%16] !== 24'hFFFFFF || rd_addr_log[(base+1)%16] !== 24'h000000) begin
            fails++; $display("FAIL read_addrs: got %h %h expected FFFFFF 000000",
                              rd_addr_log[base%16], rd_addr_log[(base+1)%16]);
        end
    endtask

    task automatic test_sse();
        logic [7:0] rx, s0, s3;
        int base;
        base = er_cnt;
        spi_begin();
        spi_byte(8'h20, rx); spi_byte(8'h01, rx); spi_byte(8'h23, rx); spi_byte(8'h45, rx);
        spi_end();
        tests++;
        if (er_cnt - base !== 0 || status !== 8'h00) begin
            fails++; $display("FAIL sse_no_wel: erases=%0d status=%h expected 0/00", er_cnt - base, status);
        end
        spi_cmd(8'h06);
        spi_begin();
        spi_byte(8'h20, rx); spi_byte(8'h01, rx); spi_byte(8'h23, rx); spi_byte(8'h45, rx);
        spi_end();
        tests++;
        if (er_cnt - base !== 1 || er_addr !== 24'h012000) begin
            fails++; $display("FAIL sse_erase: erases=%0d addr=%h expected 1 at 012000", er_cnt - base, er_addr);
        end
        tests++;
        if (status !== 8'h01) begin fails++; $display("FAIL sse_wip: status got %h expected 01", status); end
        // status stream started while busy must show WIP dropping between bytes
        spi_begin();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, s0); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h00, s3);
        spi_end();
        tests++;
        if (s0 !== 8'h01 || s3 !== 8'h00) begin
            fails++; $display("FAIL rdsr_resnap: got %h..%h expected 01..00", s0, s3);
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] rx;
        int wbase;
        spi_cmd(8'h06);
        spi_begin();
        spi_byte(8'h20, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx);
        spi_end();
        wbase = wr_cnt;
        spi_cmd(8'h06);
        spi_begin();
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
        spi_byte(8'h55, rx);
        spi_end();
        tick(BUSY);
        tests++;
        if (wr_cnt - wbase !== 0) begin fails++; $display("FAIL busy_pp_ignored: writes got %0d expected 0", wr_cnt - wbase); end
        tests++;
        if (status !== 8'h00) begin fails++; $display("FAIL busy_wren_ignored: status got %h expected 00", status); end
    endtask

    task automatic test_partial_byte();
        logic [7:0] rx;
        int wbase;
        wbase = wr_cnt;
        spi_cmd(8'h06);
        spi_begin();
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h40, rx);
        spi_bits(8'hA5, 5, rx);
        spi_end();
        tests++;
        if (wr_cnt - wbase !== 0 || status !== 8'h02) begin
            fails++; $display("FAIL partial_byte: writes=%0d status=%h expected 0/02", wr_cnt - wbase, status);
        end
        spi_cmd(8'h04);
        tests++;
        if (status !== 8'h00) begin fails++; $display("FAIL wrdi: status got %h expected 00", status); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx, d0;
        spi_cmd(8'h06);
        spi_begin();
        spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
        spi_byte(8'h00, d0);
        spi_bits(8'h00, 4, rx);
        tests++;
        if (d0 !== 8'h10 || cipo_t !== 1'b0 || status !== 8'h02) begin
            fails++; $display("FAIL mid_read_pre: data=%h cipo_t=%b status=%h expected 10/0/02", d0, cipo_t, status);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (cipo_t !== 1'b1 || status !== 8'h00) begin
            fails++; $display("FAIL mid_read_reset: cipo_t=%b status=%h expected 1/00", cipo_t, status);
        end
        tick(2);
        csn = 1'b1; sck = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        spi_begin();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        spi_end();
        tests++;
        if (rx !== 8'h00) begin fails++; $display("FAIL post_reset_rdsr: got %h expected 00", rx); end
        spi_begin();
        spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h05, rx);
        spi_byte(8'h00, d0);
        spi_end();
        tests++;
        if (d0 !== 8'h05) begin fails++; $display("FAIL post_reset_read: got %h expected 05", d0); end
    endtask

    initial begin
        test_reset();
        test_rdsr_wel();
        test_pp_wrap();
        test_read_wrap();
        test_sse();
        test_busy_ignore();
        test_partial_byte();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
